// File: rtl/ps2_rx_ctrl.sv
// PS/2 frame receiver: 2-flop synchronizers, kbclk glitch filter, start/data/parity/stop FSM with timeout.
// Optional build macro PS2_PARITY_CHECK_EN: when defined, odd parity is enforced; otherwise it is ignored.
module ps2_rx_ctrl #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kbclk,
  input  logic       in,
  output logic [7:0] code,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0]    FILT_MAX = 8'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    kbclk_sync_reg;
  logic [1:0]    in_sync_reg;
  logic          filt_reg;
  logic [7:0]    filt_cnt_reg;
  logic          fall_reg;
  logic          data_s;

  state_t        state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    sr_reg, sr_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic [7:0]    code_reg, code_next;
  logic          valid_reg, valid_next;
  logic          err_reg, err_next;
  logic          tmo_hit;
  logic          frame_ok;

  assign data_s  = in_sync_reg[1];
  assign tmo_hit = (state_reg != IDLE) && (tmo_reg == TMO_MAX);

  // Filtered kbclk flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbclk_sync_reg <= 2'b11;
      in_sync_reg    <= 2'b11;
      filt_reg       <= 1'b1;
      filt_cnt_reg   <= '0;
      fall_reg       <= 1'b0;
    end else begin
      kbclk_sync_reg <= {kbclk_sync_reg[0], kbclk};
      in_sync_reg    <= {in_sync_reg[0], in};
      fall_reg       <= 1'b0;
      if (kbclk_sync_reg[1] != filt_reg) begin
        if (filt_cnt_reg == FILT_MAX) begin
          filt_reg     <= ~filt_reg;
          filt_cnt_reg <= '0;
          fall_reg     <= filt_reg;
        end else begin
          filt_cnt_reg <= filt_cnt_reg + 8'd1;
        end
      end else begin
        filt_cnt_reg <= '0;
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_reg <= 1'b0;
    end else if (state_reg == PARITY && fall_reg && !tmo_hit) begin
      par_reg <= data_s;
    end
  end

  assign frame_ok = data_s & (^{sr_reg, par_reg});
`else
  assign frame_ok = data_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      sr_reg      <= '0;
      tmo_reg     <= '0;
      code_reg    <= '0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      sr_reg      <= sr_next;
      tmo_reg     <= tmo_next;
      code_reg    <= code_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
    end
  end

  // Timeout wins over a coincident fall and abandons the partial byte.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    sr_next      = sr_reg;
    tmo_next     = tmo_reg;
    code_next    = code_reg;
    valid_next   = 1'b0;
    err_next     = 1'b0;
    if (tmo_hit) begin
      state_next   = IDLE;
      bit_cnt_next = '0;
      tmo_next     = '0;
      err_next     = 1'b1;
    end else begin
      tmo_next = (state_reg == IDLE || fall_reg) ? '0 : tmo_reg + 1'b1;
      if (fall_reg) begin
        case (state_reg)
          IDLE: begin
            if (!data_s) begin
              state_next   = DATA;
              bit_cnt_next = '0;
            end
          end
          DATA: begin
            sr_next      = {data_s, sr_reg[7:1]};
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) state_next = PARITY;
          end
          PARITY: state_next = STOP;
          STOP: begin
            if (frame_ok) begin
              code_next  = sr_reg;
              valid_next = 1'b1;
            end else begin
              err_next = 1'b1;
            end
            state_next   = IDLE;
            bit_cnt_next = '0;
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    busy  = (state_reg != IDLE);
    code  = code_reg;
    valid = valid_reg;
    err   = err_reg;
  end

endmodule
